hdelay_sched: RTL and testbench

//   Runtime-programmable delay-line controller: generalises the fixed one-cycle delay

---
 rtl/hdelay_sched.sv | 124 ++++++++++++
 tb/tb_hdelay_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdelay_sched.sv
// Programmable D-cycle delay line: circular buffer with per-sample valid tags,
// runtime delay reconfiguration and a flush that masks stale in-flight samples.
module hdelay_sched #(
  parameter int   DATA_WIDTH    = 8,
  parameter int   MAX_DELAY     = 16,
  parameter int   PTR_W         = 4,
  parameter int   DEFAULT_DELAY = 1,
  parameter logic HINITIAL      = 1'b0
) (
  input  logic                  hclk,
  input  logic                  hres,
  input  logic [DATA_WIDTH-1:0] hin,
  input  logic                  hin_valid,
  input  logic                  hcfg_load,
  input  logic [PTR_W:0]        hcfg_delay,
  output logic [DATA_WIDTH-1:0] hout,
  output logic                  hout_valid,
  output logic                  hbusy,
  output logic [PTR_W:0]        hdelay_cur,
  output logic                  hcfg_err,
  output logic                  dbg_state
);

  // Valid semantics: hin_valid qualifies hin on the same edge and travels with it
  // through the buffer; there is no backpressure, hout_valid qualifies hout.

  localparam logic [PTR_W:0] MAX_D = (PTR_W+1)'(MAX_DELAY);
  localparam logic [PTR_W:0] DEF_D = (PTR_W+1)'(DEFAULT_DELAY);
  localparam logic [PTR_W:0] ONE_D = (PTR_W+1)'(1);

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [PTR_W:0]        flush_cnt, flush_cnt_nxt;
  logic [PTR_W:0]        delay_nxt;
  logic [PTR_W:0]        clamp_delay;
  logic                  clamp_err;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  logic [DATA_WIDTH-1:0] data_mem [MAX_DELAY];
  logic [MAX_DELAY-1:0]  valid_tag;

  // Out-of-range requests are clamped into 1..MAX_DELAY and flagged.
  always_comb begin
    clamp_delay = hcfg_delay;
    clamp_err   = 1'b0;
    if (hcfg_delay == '0) begin
      clamp_delay = ONE_D;
      clamp_err   = 1'b1;
    end else if (hcfg_delay > MAX_D) begin
      clamp_delay = MAX_D;
      clamp_err   = 1'b1;
    end
  end

  // Slot written D-1 edges ago; D=MAX_DELAY truncates to 0 and reads wptr+1.
  assign rptr = wptr + PTR_W'(1) - hdelay_cur[PTR_W-1:0];

  // D=1 reads the slot being written this edge, so take hin directly.
  always_comb begin
    rd_data  = data_mem[rptr];
    rd_valid = valid_tag[rptr];
    if (hdelay_cur == ONE_D) begin
      rd_data  = hin;
      rd_valid = hin_valid;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    delay_nxt     = hdelay_cur;
    if (hcfg_load) begin
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = clamp_delay;
      delay_nxt     = clamp_delay;
    end else if (state == ST_FLUSH) begin
      if (flush_cnt <= ONE_D) begin
        state_nxt     = ST_RUN;
        flush_cnt_nxt = '0;
      end else begin
        flush_cnt_nxt = flush_cnt - ONE_D;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hres) begin
      state      <= ST_FLUSH;
      flush_cnt  <= DEF_D;
      hdelay_cur <= DEF_D;
      wptr       <= '0;
      hout       <= {DATA_WIDTH{HINITIAL}};
      hout_valid <= 1'b0;
      hcfg_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      hdelay_cur <= delay_nxt;
      wptr       <= wptr + PTR_W'(1);
      hout       <= rd_data;
      hout_valid <= (state_nxt == ST_RUN) && rd_valid;
      hcfg_err   <= hcfg_load && clamp_err;
    end
  end

  // Buffer contents survive reset; stale entries are hidden by the flush.
  always_ff @(posedge hclk) begin
    if (!hres) begin
      data_mem[wptr]  <= hin;
      valid_tag[wptr] <= hin_valid;
    end
  end

  assign hbusy     = (state == ST_FLUSH);
  assign dbg_state = state;

endmodule

// File: tb/tb_hdelay_sched.sv
// Bench for hdelay_sched: directed script, history-based reference model checked
// every cycle, plus literal expectations at key edges.
module tb_hdelay_sched;

  localparam int DW   = 8;
  localparam int MAXD = 16;
  localparam int PW   = 4;
  localparam int DEFD = 1;

  logic          hclk = 1'b0;
  logic          hres = 1'b1;
  logic [DW-1:0] hin = '0;
  logic          hin_valid = 1'b0;
  logic          hcfg_load = 1'b0;
  logic [PW:0]   hcfg_delay = '0;
  logic [DW-1:0] hout;
  logic          hout_valid;
  logic          hbusy;
  logic [PW:0]   hdelay_cur;
  logic          hcfg_err;
  logic          dbg_state;

  hdelay_sched #(
    .DATA_WIDTH(DW), .MAX_DELAY(MAXD), .PTR_W(PW),
    .DEFAULT_DELAY(DEFD), .HINITIAL(1'b0)
  ) dut (
    .hclk(hclk), .hres(hres), .hin(hin), .hin_valid(hin_valid),
    .hcfg_load(hcfg_load), .hcfg_delay(hcfg_delay), .hout(hout),
    .hout_valid(hout_valid), .hbusy(hbusy), .hdelay_cur(hdelay_cur),
    .hcfg_err(hcfg_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  int tests = 0;
  int fails = 0;

  // Model: input history per edge, plus the edge the current flush started and D.
  int            cyc = -1;
  bit            started = 1'b0;
  bit            m_reset = 1'b0;
  int            m_start = 0;
  int            m_d = DEFD;
  bit            m_err = 1'b0;
  logic [DW-1:0] hist_d [0:1023];
  bit            hist_v [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // driver: apply inputs for one edge, then advance the model for that edge
  task automatic step(input bit r, input logic [DW-1:0] d, input bit v,
                      input bit ld, input logic [PW:0] dl);
    hres       = r;
    hin        = d;
    hin_valid  = v;
    hcfg_load  = ld;
    hcfg_delay = dl;
    @(posedge hclk);
    cyc++;
    started = 1'b1;
    if (r) begin
      m_reset = 1'b1;
      m_start = cyc;
      m_d     = DEFD;
      m_err   = 1'b0;
    end else begin
      m_reset      = 1'b0;
      hist_d[cyc]  = d;
      hist_v[cyc]  = v;
      m_err        = 1'b0;
      if (ld) begin
        m_start = cyc;
        if (dl == 0) begin
          m_d = 1; m_err = 1'b1;
        end else if (int'(dl) > MAXD) begin
          m_d = MAXD; m_err = 1'b1;
        end else begin
          m_d = int'(dl);
        end
      end
    end
    #2;
  endtask

  // scoreboard compare process
  bit e_busy;
  bit e_valid;
  int src;
  always @(negedge hclk) begin
    if (started) begin
      if (m_reset) begin
        check("rst_hout", 32'(hout), 32'(0));
        check("rst_hout_valid", 32'(hout_valid), 32'(0));
        check("rst_hbusy", 32'(hbusy), 32'(1));
        check("rst_hdelay_cur", 32'(hdelay_cur), 32'(DEFD));
        check("rst_hcfg_err", 32'(hcfg_err), 32'(0));
      end else begin
        e_busy  = (cyc < m_start + m_d);
        e_valid = 1'b0;
        if (!e_busy) begin
          src     = cyc - m_d + 1;
          e_valid = hist_v[src];
        end
        check("hbusy", 32'(hbusy), 32'(e_busy));
        check("hout_valid", 32'(hout_valid), 32'(e_valid));
        check("hdelay_cur", 32'(hdelay_cur), 32'(m_d));
        check("hcfg_err", 32'(hcfg_err), 32'(m_err));
        if (e_valid) check("hout", 32'(hout), 32'(hist_d[src]));
      end
    end
  end

  initial begin
    // 1: reset then D=1 streaming
    step(1'b1, 8'hFF, 1'b1, 1'b0, '0);
    check("t1_rst_hout", 32'(hout), 32'h00);
    check("t1_rst_busy", 32'(hbusy), 32'd1);
    check("t1_rst_dcur", 32'(hdelay_cur), 32'd1);
    for (int e = 1; e <= 9; e++) begin
      step(1'b0, 8'(e), 1'b1, 1'b0, '0);
      if (e == 1) begin
        check("t1_e1_hout", 32'(hout), 32'h01);
        check("t1_e1_valid", 32'(hout_valid), 32'd1);
        check("t1_e1_busy", 32'(hbusy), 32'd0);
      end
      if (e == 5) check("t1_e5_hout", 32'(hout), 32'h05);
    end

    // 2: load D=5 at edge 10
    for (int e = 10; e <= 29; e++) begin
      step(1'b0, 8'(16 + e), 1'b1, e == 10, 5'd5);
      if (e == 10) check("t2_dcur", 32'(hdelay_cur), 32'd5);
      if (e == 14) begin
        check("t2_e14_valid", 32'(hout_valid), 32'd0);
        check("t2_e14_busy", 32'(hbusy), 32'd1);
      end
      if (e == 15) begin
        check("t2_e15_valid", 32'(hout_valid), 32'd1);
        check("t2_e15_hout", 32'(hout), 32'h1B);
      end
      if (e == 20) check("t2_e20_hout", 32'(hout), 32'h20);
    end

    // 3: D=16 across two pointer wraps
    for (int e = 30; e <= 75; e++) begin
      step(1'b0, 8'(e), 1'b1, e == 30, 5'd16);
      if (e == 30) begin
        check("t3_dcur", 32'(hdelay_cur), 32'd16);
        check("t3_err", 32'(hcfg_err), 32'd0);
      end
      if (e == 45) check("t3_e45_valid", 32'(hout_valid), 32'd0);
      if (e == 46) begin
        check("t3_e46_valid", 32'(hout_valid), 32'd1);
        check("t3_e46_hout", 32'(hout), 32'd31);
      end
      if (e == 70) check("t3_e70_hout", 32'(hout), 32'd55);
    end

    // 4: clamped loads 0 and 31
    for (int e = 76; e <= 82; e++) begin
      step(1'b0, 8'(e), 1'b1, (e == 76) || (e == 78), (e == 76) ? 5'd0 : 5'd31);
      if (e == 76) begin
        check("t4_zero_dcur", 32'(hdelay_cur), 32'd1);
        check("t4_zero_err", 32'(hcfg_err), 32'd1);
      end
      if (e == 77) check("t4_err_clear", 32'(hcfg_err), 32'd0);
      if (e == 78) begin
        check("t4_big_dcur", 32'(hdelay_cur), 32'd16);
        check("t4_big_err", 32'(hcfg_err), 32'd1);
      end
      if (e == 79) check("t4_err_clear2", 32'(hcfg_err), 32'd0);
    end

    // 5: load D=8, reload D=3 mid-flush
    for (int e = 83; e <= 100; e++) begin
      step(1'b0, 8'(e), 1'b1, (e == 83) || (e == 87), (e == 83) ? 5'd8 : 5'd3);
      if (e == 87) begin
        check("t5_err", 32'(hcfg_err), 32'd0);
        check("t5_dcur", 32'(hdelay_cur), 32'd3);
      end
      if (e == 89) check("t5_e89_valid", 32'(hout_valid), 32'd0);
      if (e == 90) begin
        check("t5_e90_valid", 32'(hout_valid), 32'd1);
        check("t5_e90_hout", 32'(hout), 32'd88);
      end
      if (e == 95) check("t5_e95_hout", 32'(hout), 32'd93);
    end

    // 6: alternating valid, then reset together with a load
    for (int e = 101; e <= 110; e++) begin
      step(1'b0, 8'(e), e[0], 1'b0, '0);
      if (e == 105) begin
        check("t6_e105_valid", 32'(hout_valid), 32'd1);
        check("t6_e105_hout", 32'(hout), 32'd103);
      end
      if (e == 106) check("t6_e106_valid", 32'(hout_valid), 32'd0);
    end
    step(1'b1, 8'hEE, 1'b1, 1'b1, 5'd7);
    check("t6_rst_hout", 32'(hout), 32'h00);
    check("t6_rst_valid", 32'(hout_valid), 32'd0);
    check("t6_rst_busy", 32'(hbusy), 32'd1);
    check("t6_rst_dcur", 32'(hdelay_cur), 32'd1);
    check("t6_rst_err", 32'(hcfg_err), 32'd0);
    for (int e = 112; e <= 130; e++) begin
      step(1'b0, 8'(e), e[0], 1'b0, '0);
      if (e == 112) begin
        check("t6_e112_valid", 32'(hout_valid), 32'd0);
        check("t6_e112_busy", 32'(hbusy), 32'd0);
      end
      if (e == 113) begin
        check("t6_e113_valid", 32'(hout_valid), 32'd1);
        check("t6_e113_hout", 32'(hout), 32'd113);
      end
    end

    // reloading the current delay still flushes
    for (int e = 131; e <= 140; e++) begin
      step(1'b0, 8'(e), 1'b1, e == 131, 5'd1);
      if (e == 131) begin
        check("t7_busy", 32'(hbusy), 32'd1);
        check("t7_valid", 32'(hout_valid), 32'd0);
      end
      if (e == 132) begin
        check("t7_e132_busy", 32'(hbusy), 32'd0);
        check("t7_e132_hout", 32'(hout), 32'd132);
      end
    end

    // final report
    @(negedge hclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
